// File: rtl/elixirchip_es1_spu_op_logic.sv
// Lane-parallel bitwise logic unit with optional clear, valid and accumulate
// modes, followed by a LATENCY-deep clock-enabled output pipeline.
module elixirchip_es1_spu_op_logic #(
  parameter int                           LATENCY         = 1,
  parameter int                           LANES           = 1,
  parameter int                           DATA_BITS       = 8,
  parameter logic [LANES*DATA_BITS-1:0]   CLEAR_DATA      = '0,
  parameter int                           IMMEDIATE_DATA1 = 0,
  parameter int                           USE_CLEAR       = 0,
  parameter int                           USE_VALID       = 0,
  parameter int                           USE_ACCUM       = 0,
  parameter string                        DEVICE          = "RTL",
  parameter string                        SIMULATION      = "false",
  parameter string                        DEBUG           = "false"
) (
  input  logic                           reset,
  input  logic                           clk,
  input  logic                           cke,
  input  logic [2:0]                     s_op,
  input  logic [LANES*DATA_BITS-1:0]     s_data0,
  input  logic [LANES*DATA_BITS-1:0]     s_data1,
  input  logic                           s_clear,
  input  logic                           s_valid,
  output logic [LANES*DATA_BITS-1:0]     m_data,
  output logic                           m_valid
);

  localparam int W = LANES * DATA_BITS;

  generate
    if (LATENCY < 0 || LANES < 1 || (USE_ACCUM != 0 && LATENCY == 0)) begin : g_param_err
      $error("elixirchip_es1_spu_op_logic: illegal LATENCY/LANES/USE_ACCUM combination");
    end
  endgenerate

  function automatic logic [W-1:0] op_f(input logic [2:0] op,
                                        input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    logic [W-1:0] res;
    res = '0;
    case (op)
      3'd0: res = a & b;
      3'd1: res = a | b;
      3'd2: res = a ^ b;
      3'd3: res = ~(a ^ b);
      3'd4: res = ~(a & b);
      3'd5: res = ~(a | b);
      3'd6: res = a & ~b;
      3'd7: res = a | ~b;
      default: res = '0;
    endcase
    return res;
  endfunction

  logic         clr;
  logic         vld;
  logic [W-1:0] op_res;
  logic [W-1:0] r;
  logic         v;

  assign clr    = (USE_CLEAR != 0) ? s_clear : 1'b0;
  assign vld    = (USE_VALID != 0) ? s_valid : 1'b1;
  assign op_res = op_f(s_op, s_data0, s_data1);
  assign r      = clr ? CLEAR_DATA : op_res;
  assign v      = vld;

  generate
    if (LATENCY == 0) begin : g_comb
      assign m_data  = r;
      assign m_valid = v;
    end else begin : g_pipe
      logic [LATENCY-1:0][W-1:0] data_q;
      logic [LATENCY-1:0]        valid_q;
      logic [W-1:0]              st1_data_d;
      logic                      st1_valid_d;

      // In accumulate mode stage 1 is the accumulator itself, fed back as operand A.
      always_comb begin
        st1_data_d  = r;
        st1_valid_d = v;
        if (USE_ACCUM != 0) begin
          st1_valid_d = vld;
          if (vld) begin
            st1_data_d = clr ? op_res : op_f(s_op, data_q[0], s_data1);
          end else if (clr) begin
            st1_data_d = CLEAR_DATA;
          end else begin
            st1_data_d = data_q[0];
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          data_q  <= '0;
          valid_q <= '0;
        end else if (cke) begin
          data_q[0]  <= st1_data_d;
          valid_q[0] <= st1_valid_d;
          for (int unsigned i = 1; i < LATENCY; i++) begin
            data_q[i]  <= data_q[i-1];
            valid_q[i] <= valid_q[i-1];
          end
        end
      end

      assign m_data  = data_q[LATENCY-1];
      assign m_valid = valid_q[LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_elixirchip_es1_spu_op_logic.sv
// Directed bench: several parameterisations of the logic unit driven from one
// shared stimulus sequence with hand-computed expectations.
module tb_elixirchip_es1_spu_op_logic;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic [2:0]  op;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        clear;
  logic        valid;

  logic [15:0] l2_data;  logic l2_valid;
  logic [7:0]  l1_data;  logic l1_valid;
  logic [7:0]  l3_data;  logic l3_valid;
  logic [7:0]  l0_data;  logic l0_valid;
  logic [7:0]  ac_data;  logic ac_valid;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_sw [8] = '{8'h88, 8'hEE, 8'h66, 8'h99, 8'h77, 8'h11, 8'h42, 8'hDB};

  always #5 clk = ~clk;

  elixirchip_es1_spu_op_logic #(.LATENCY(2), .LANES(2), .DATA_BITS(8), .USE_VALID(1)) u_l2 (
    .reset(reset), .clk(clk), .cke(cke), .s_op(op), .s_data0(a16), .s_data1(b16),
    .s_clear(clear), .s_valid(valid), .m_data(l2_data), .m_valid(l2_valid));

  elixirchip_es1_spu_op_logic #(.LATENCY(1), .DATA_BITS(8), .USE_VALID(1), .USE_CLEAR(1),
                                .CLEAR_DATA(8'h5A)) u_l1 (
    .reset(reset), .clk(clk), .cke(cke), .s_op(op), .s_data0(a8), .s_data1(b8),
    .s_clear(clear), .s_valid(valid), .m_data(l1_data), .m_valid(l1_valid));

  elixirchip_es1_spu_op_logic #(.LATENCY(3), .DATA_BITS(8), .USE_VALID(1)) u_l3 (
    .reset(reset), .clk(clk), .cke(cke), .s_op(op), .s_data0(a8), .s_data1(b8),
    .s_clear(clear), .s_valid(valid), .m_data(l3_data), .m_valid(l3_valid));

  elixirchip_es1_spu_op_logic #(.LATENCY(0), .DATA_BITS(8)) u_l0 (
    .reset(reset), .clk(clk), .cke(cke), .s_op(op), .s_data0(a8), .s_data1(b8),
    .s_clear(clear), .s_valid(valid), .m_data(l0_data), .m_valid(l0_valid));

  elixirchip_es1_spu_op_logic #(.LATENCY(1), .DATA_BITS(8), .USE_VALID(1), .USE_CLEAR(1),
                                .USE_ACCUM(1), .CLEAR_DATA(8'h5A)) u_acc (
    .reset(reset), .clk(clk), .cke(cke), .s_op(op), .s_data0(a8), .s_data1(b8),
    .s_clear(clear), .s_valid(valid), .m_data(ac_data), .m_valid(ac_valid));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cke = 1'b1; op = 3'd0; a8 = '0; b8 = '0;
    a16 = '0; b16 = '0; clear = 1'b0; valid = 1'b0;
    tick(); tick();

    chk("rst_l1_data", {8'h0, l1_data}, 16'h0);
    chk("rst_l1_valid", {15'h0, l1_valid}, 16'h0);
    chk("rst_l2_data", l2_data, 16'h0);
    chk("rst_l2_valid", {15'h0, l2_valid}, 16'h0);
    chk("rst_l3_valid", {15'h0, l3_valid}, 16'h0);
    chk("rst_acc_data", {8'h0, ac_data}, 16'h0);
    chk("rst_acc_valid", {15'h0, ac_valid}, 16'h0);

    // Combinational path ignores reset.
    op = 3'd2; a8 = 8'hCA; b8 = 8'hAC;
    #1;
    chk("l0_in_reset_data", {8'h0, l0_data}, 16'h0066);
    chk("l0_in_reset_valid", {15'h0, l0_valid}, 16'h1);
    reset = 1'b0;
    valid = 1'b1;

    for (int i = 0; i < 8; i++) begin
      op = 3'(i);
      #1;
      chk($sformatf("l0_op%0d", i), {8'h0, l0_data}, {8'h0, exp_sw[i]});
      tick();
      chk($sformatf("l1_op%0d", i), {8'h0, l1_data}, {8'h0, exp_sw[i]});
      chk($sformatf("l1_op%0d_v", i), {15'h0, l1_valid}, 16'h1);
    end

    valid = 1'b0;
    tick(); tick(); tick();

    op = 3'd3; a16 = 16'h0F0F; b16 = 16'h00FF; valid = 1'b1;
    tick();
    chk("l2_lat1_valid", {15'h0, l2_valid}, 16'h0);
    valid = 1'b0;
    tick();
    chk("l2_xnor_data", l2_data, 16'hF00F);
    chk("l2_xnor_valid", {15'h0, l2_valid}, 16'h1);
    tick();
    chk("l2_after_valid", {15'h0, l2_valid}, 16'h0);
    tick(); tick(); tick();

    // LATENCY=3 stream with a 3-cycle clock-enable gap.
    a8 = 8'hCA; b8 = 8'hAC; valid = 1'b1;
    op = 3'd0; tick();
    chk("l3_b0_valid", {15'h0, l3_valid}, 16'h0);
    op = 3'd1; tick();
    chk("l3_b1_valid", {15'h0, l3_valid}, 16'h0);
    op = 3'd2; tick();
    chk("l3_out0_data", {8'h0, l3_data}, 16'h0088);
    chk("l3_out0_valid", {15'h0, l3_valid}, 16'h1);
    cke = 1'b0; op = 3'd7; a8 = 8'h00; b8 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("l3_frozen%0d_data", i), {8'h0, l3_data}, 16'h0088);
      chk($sformatf("l3_frozen%0d_valid", i), {15'h0, l3_valid}, 16'h1);
    end
    cke = 1'b1; a8 = 8'hCA; b8 = 8'hAC;
    op = 3'd3; tick();
    chk("l3_out1_data", {8'h0, l3_data}, 16'h00EE);
    op = 3'd4; tick();
    chk("l3_out2_data", {8'h0, l3_data}, 16'h0066);
    valid = 1'b0; tick();
    chk("l3_out3_data", {8'h0, l3_data}, 16'h0099);
    tick();
    chk("l3_out4_data", {8'h0, l3_data}, 16'h0077);
    chk("l3_out4_valid", {15'h0, l3_valid}, 16'h1);
    tick();
    chk("l3_drain_valid", {15'h0, l3_valid}, 16'h0);

    // Accumulate mode (AND chain), plus clear on the non-accumulating unit.
    op = 3'd0; clear = 1'b1; valid = 1'b1; a8 = 8'hFF; b8 = 8'hF0;
    tick();
    chk("acc_beat0", {8'h0, ac_data}, 16'h00F0);
    chk("acc_beat0_v", {15'h0, ac_valid}, 16'h1);
    chk("l1_clear_data", {8'h0, l1_data}, 16'h005A);
    clear = 1'b0; b8 = 8'h3C; tick();
    chk("acc_beat1", {8'h0, ac_data}, 16'h0030);
    b8 = 8'h0C; tick();
    chk("acc_beat2", {8'h0, ac_data}, 16'h0000);
    clear = 1'b1; valid = 1'b0; tick();
    chk("acc_clr_novalid", {8'h0, ac_data}, 16'h005A);
    chk("acc_clr_novalid_v", {15'h0, ac_valid}, 16'h0);
    clear = 1'b0; tick();
    chk("acc_hold", {8'h0, ac_data}, 16'h005A);
    op = 3'd1; valid = 1'b1; b8 = 8'h01; tick();
    chk("acc_or", {8'h0, ac_data}, 16'h005B);
    op = 3'd2; b8 = 8'hFF; tick();
    chk("acc_xor", {8'h0, ac_data}, 16'h00A4);

    // Asynchronous reset mid-accumulation, between clock edges.
    #2 reset = 1'b1;
    #1;
    chk("acc_async_rst_data", {8'h0, ac_data}, 16'h0);
    chk("acc_async_rst_valid", {15'h0, ac_valid}, 16'h0);
    chk("l1_async_rst_valid", {15'h0, l1_valid}, 16'h0);
    tick();
    reset = 1'b0;
    op = 3'd1; b8 = 8'h0F; tick();
    chk("acc_after_rst", {8'h0, ac_data}, 16'h000F);
    cke = 1'b0; b8 = 8'hF0; tick();
    chk("acc_cke_hold", {8'h0, ac_data}, 16'h000F);
    cke = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
